// File: rtl/hcsr04_emulador_if.sv
// Trigger/echo signal bundle between a sonar interface (master) and the
// HC-SR04 emulator (slave). The falha line exists only when ECHO_DROP_EN
// is defined.
interface hcsr04_emulador_if;
   logic        trigger;
   logic [11:0] distancia;
`ifdef ECHO_DROP_EN
   logic        falha;
`endif
   logic        echo;
   logic        ocupado;
   logic [3:0]  db_estado;

`ifdef ECHO_DROP_EN
   modport master (output trigger, distancia, falha, input echo, ocupado, db_estado);
   modport slave  (input trigger, distancia, falha, output echo, ocupado, db_estado);
`else
   modport master (output trigger, distancia, input echo, ocupado, db_estado);
   modport slave  (input trigger, distancia, output echo, ocupado, db_estado);
`endif
endinterface

// File: rtl/hcsr04_emulador.sv
// HC-SR04 sensor emulator: accepts a trigger pulse and answers with an echo
// pulse whose width encodes a programmed BCD distance in cm.
// Optional build macro ECHO_DROP_EN: adds the falha input; when it is high
// at trigger acceptance the echo is suppressed (SEM_ECO) to exercise the
// interface timeout path.
module hcsr04_emulador #(
   parameter int unsigned TICKS_PER_CM   = 2941,
   parameter int unsigned TRIG_MIN       = 500,
   parameter int unsigned DELAY_TICKS    = 10000,
   parameter int unsigned MAX_CM         = 400,
   parameter int unsigned ECHO_MAX_TICKS = 1900000,
   parameter int unsigned HOLDOFF_TICKS  = 50000
) (
   input  logic               clock,
   input  logic               reset,
   hcsr04_emulador_if.slave   bus
);

   localparam int unsigned LIM_A   = (DELAY_TICKS > ECHO_MAX_TICKS) ? DELAY_TICKS : ECHO_MAX_TICKS;
   localparam int unsigned LIM_B   = (LIM_A > HOLDOFF_TICKS) ? LIM_A : HOLDOFF_TICKS;
   localparam int unsigned CNT_LIM = (LIM_B > TRIG_MIN) ? LIM_B : TRIG_MIN;
   localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);
   localparam int unsigned PRE_W   = $clog2(TICKS_PER_CM + 1);

   typedef enum logic [3:0] {
      IDLE    = 4'h0,
      TRIG    = 4'h1,
      ESPERA  = 4'h2,
      ECO     = 4'h3,
      HOLDOFF = 4'h4,
      SEM_ECO = 4'h5
   } estado_t;

   estado_t            estado, estado_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [PRE_W-1:0]   presc, presc_nxt;
   logic [10:0]        cm_rest, cm_nxt;
   logic               modo_max, modo_max_nxt;
   logic               trig_ant;
   logic [11:0]        dist_q, dist_nxt;
   logic               echo_q, ocupado_q;
`ifdef ECHO_DROP_EN
   logic               falha_q, falha_nxt;
`endif

   // Decimal value of a {hundreds,tens,units} BCD word; 11 bits so that
   // illegal digits cannot wrap into a plausible in-range value.
   function automatic logic [10:0] bcd_para_cm(input logic [11:0] d);
      bcd_para_cm = 11'(d[11:8]) * 11'd100 + 11'(d[7:4]) * 11'd10 + 11'(d[3:0]);
   endfunction

   // True when the echo must use the no-object width instead of N cm.
   function automatic logic fora_de_faixa(input logic [11:0] d);
      logic [10:0] n;
      n = bcd_para_cm(d);
      fora_de_faixa = (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9) ||
                      (n == 11'd0) || (n > 11'(MAX_CM));
   endfunction

   // Next-state and counter logic for the trigger/echo sequence.
   always_comb begin
      estado_nxt   = estado;
      cnt_nxt      = cnt;
      presc_nxt    = presc;
      cm_nxt       = cm_rest;
      modo_max_nxt = modo_max;
      dist_nxt     = dist_q;
`ifdef ECHO_DROP_EN
      falha_nxt    = falha_q;
`endif
      case (estado)
         IDLE: begin
            // Only a 0 -> 1 transition counts; a level already high waits.
            if (bus.trigger && !trig_ant) begin
               estado_nxt = TRIG;
               cnt_nxt    = '0;
            end
         end
         TRIG: begin
            if (bus.trigger) begin
               // Saturate once the minimum width is reached.
               if (cnt < CNT_W'(TRIG_MIN)) cnt_nxt = cnt + 1'b1;
            end else if (cnt >= CNT_W'(TRIG_MIN)) begin
               estado_nxt = ESPERA;
               cnt_nxt    = '0;
               dist_nxt   = bus.distancia;
`ifdef ECHO_DROP_EN
               falha_nxt  = bus.falha;
`endif
            end else begin
               estado_nxt = IDLE;
            end
         end
         ESPERA: begin
            if (cnt == CNT_W'(DELAY_TICKS - 1)) begin
               cnt_nxt      = '0;
               presc_nxt    = '0;
               cm_nxt       = bcd_para_cm(dist_q);
               modo_max_nxt = fora_de_faixa(dist_q);
`ifdef ECHO_DROP_EN
               estado_nxt   = falha_q ? SEM_ECO : ECO;
`else
               estado_nxt   = ECO;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ECO: begin
            if (modo_max) begin
               if (cnt == CNT_W'(ECHO_MAX_TICKS - 1)) begin
                  estado_nxt = HOLDOFF;
                  cnt_nxt    = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else if (presc == PRE_W'(TICKS_PER_CM - 1)) begin
               // One cm of echo elapsed; leave after the last one.
               presc_nxt = '0;
               if (cm_rest == 11'd1) begin
                  estado_nxt = HOLDOFF;
                  cnt_nxt    = '0;
               end else begin
                  cm_nxt = cm_rest - 1'b1;
               end
            end else begin
               presc_nxt = presc + 1'b1;
            end
         end
         SEM_ECO: begin
            if (cnt == CNT_W'(ECHO_MAX_TICKS - 1)) begin
               estado_nxt = HOLDOFF;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HOLDOFF: begin
            if (cnt == CNT_W'(HOLDOFF_TICKS - 1)) begin
               estado_nxt = IDLE;
               cnt_nxt    = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            estado_nxt = IDLE;
            cnt_nxt    = '0;
         end
      endcase
   end

   // State, counters and registered outputs; reset wins in every state.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= IDLE;
         cnt       <= '0;
         presc     <= '0;
         cm_rest   <= '0;
         modo_max  <= 1'b0;
         trig_ant  <= 1'b1;
         echo_q    <= 1'b0;
         ocupado_q <= 1'b0;
`ifdef ECHO_DROP_EN
         falha_q   <= 1'b0;
`endif
      end else begin
         estado    <= estado_nxt;
         cnt       <= cnt_nxt;
         presc     <= presc_nxt;
         cm_rest   <= cm_nxt;
         modo_max  <= modo_max_nxt;
         trig_ant  <= bus.trigger;
         echo_q    <= (estado_nxt == ECO);
         ocupado_q <= (estado_nxt != IDLE) && (estado_nxt != TRIG);
`ifdef ECHO_DROP_EN
         falha_q   <= falha_nxt;
`endif
      end
   end

   // Distance captured at trigger acceptance; pure data, no reset needed.
   always_ff @(posedge clock) begin
      dist_q <= dist_nxt;
   end

   assign bus.echo      = echo_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.db_estado = estado;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Scoreboard bench for hcsr04_emulador with small timing parameters.
module tb_hcsr04_emulador;

   localparam int TPC   = 4;
   localparam int TMIN  = 5;
   localparam int DLY   = 8;
   localparam int MAXCM = 400;
   localparam int EMAX  = 2000;
   localparam int HOLD  = 16;

   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;

   hcsr04_emulador_if bus();

   hcsr04_emulador #(
      .TICKS_PER_CM  (TPC),
      .TRIG_MIN      (TMIN),
      .DELAY_TICKS   (DLY),
      .MAX_CM        (MAXCM),
      .ECHO_MAX_TICKS(EMAX),
      .HOLDOFF_TICKS (HOLD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   typedef struct {
      int rise;
      int width;
      int orise;
      int ofall;
   } esperado_t;

   esperado_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference echo width for a BCD distance.
   function automatic int largura_ref(input logic [11:0] d);
      int h, t, u, n;
      h = int'(d[11:8]);
      t = int'(d[7:4]);
      u = int'(d[3:0]);
      n = h * 100 + t * 10 + u;
      if (h > 9 || t > 9 || u > 9 || n == 0 || n > MAXCM) return EMAX;
      return n * TPC;
   endfunction

   // Trigger high for 'largura' sampled cycles; t_cyc is the acceptance edge T.
   task automatic trig_pulse(input int largura, output int t_cyc);
      @(negedge clock);
      bus.trigger = 1'b1;
      repeat (largura) @(negedge clock);
      bus.trigger = 1'b0;
      t_cyc = cyc + 1;
   endtask

   task automatic espera_fim(input int limite);
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.ocupado !== 1'b0) && n < limite) begin
         @(negedge clock);
         n++;
      end
      if (n >= limite) begin
         check("timeout", n, 0);
         sb.delete();
      end
      repeat (2) @(negedge clock);
   endtask

   task automatic medida(input logic [11:0] d);
      int t, w;
      bus.distancia = d;
      w = largura_ref(d);
      trig_pulse(6, t);
      sb.push_back('{rise: t + DLY, width: w, orise: t, ofall: t + DLY + w + HOLD});
      espera_fim(w + DLY + HOLD + 100);
   endtask

   // Monitor: compares observed echo/ocupado edges against the scoreboard.
   logic echo_ant = 1'b0;
   logic ocup_ant = 1'b0;
   int   rise_c   = 0;
   bit   ativo    = 1'b0;
   always @(negedge clock) begin
      if (bus.echo === 1'b1 && echo_ant !== 1'b1) begin
         check("echo_pendente", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            check("echo_rise", cyc, sb[0].rise);
            rise_c = cyc;
            ativo  = 1'b1;
         end
      end
      if (bus.echo !== 1'b1 && echo_ant === 1'b1 && ativo && sb.size() > 0) begin
         check("echo_width", cyc - rise_c, sb[0].width);
         ativo = 1'b0;
      end
      if (bus.ocupado === 1'b1 && ocup_ant !== 1'b1 && sb.size() > 0)
         check("ocup_rise", cyc, sb[0].orise);
      if (bus.ocupado !== 1'b1 && ocup_ant === 1'b1 && sb.size() > 0) begin
         check("ocup_fall", cyc, sb[0].ofall);
         void'(sb.pop_front());
      end
      echo_ant = bus.echo;
      ocup_ant = bus.ocupado;
   end

   initial begin
      repeat (60000) @(posedge clock);
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t2;
      reset         = 1'b1;
      bus.trigger   = 1'b0;
      bus.distancia = 12'h000;
`ifdef ECHO_DROP_EN
      bus.falha     = 1'b0;
`endif
      repeat (3) @(negedge clock);
      check("rst_echo", bus.echo, 0);
      check("rst_ocupado", bus.ocupado, 0);
      check("rst_estado", bus.db_estado, 0);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // Nominal 25 cm measurement.
      medida(12'h025);

      // Short trigger is rejected.
      bus.distancia = 12'h025;
      trig_pulse(4, t);
      @(negedge clock);
      check("short_estado_T", bus.db_estado, 0);
      repeat (DLY + 10) @(negedge clock);
      check("short_ocupado", bus.ocupado, 0);
      check("short_echo", bus.echo, 0);
      check("short_estado", bus.db_estado, 0);

      // Boundaries and out-of-range codes.
      medida(12'h001);
      medida(12'h400);
      medida(12'h401);
      medida(12'h000);
      medida(12'h0A5);

      // Second trigger and distance change during ECO are ignored.
      bus.distancia = 12'h025;
      trig_pulse(6, t);
      sb.push_back('{rise: t + DLY, width: 100, orise: t, ofall: t + DLY + 100 + HOLD});
      while (cyc < t + DLY + 20) @(negedge clock);
      trig_pulse(6, t2);
      bus.distancia = 12'h399;
      espera_fim(400);
      check("mid_estado", bus.db_estado, 0);

      // Reset during the 10th echo cycle aborts the measurement.
      bus.distancia = 12'h025;
      trig_pulse(6, t);
      sb.push_back('{rise: t + DLY, width: 10, orise: t, ofall: t + DLY + 10});
      while (cyc < t + DLY + 9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rstmid_echo", bus.echo, 0);
      check("rstmid_ocupado", bus.ocupado, 0);
      check("rstmid_estado", bus.db_estado, 0);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check("rstmid_sb", sb.size(), 0);
      sb.delete();
      medida(12'h025);

`ifdef ECHO_DROP_EN
      // Dropped echo: SEM_ECO for the full timeout, then HOLDOFF.
      bus.distancia = 12'h025;
      bus.falha     = 1'b1;
      trig_pulse(6, t);
      @(negedge clock);
      bus.falha = 1'b0;
      while (cyc < t + DLY - 1) @(negedge clock);
      check("drop_espera", bus.db_estado, 2);
      @(negedge clock);
      check("drop_sem_eco", bus.db_estado, 5);
      while (cyc < t + DLY + EMAX - 1) @(negedge clock);
      check("drop_sem_eco_fim", bus.db_estado, 5);
      check("drop_echo", bus.echo, 0);
      @(negedge clock);
      check("drop_holdoff", bus.db_estado, 4);
      while (cyc < t + DLY + EMAX + HOLD - 1) @(negedge clock);
      check("drop_holdoff_ocup", bus.ocupado, 1);
      @(negedge clock);
      check("drop_idle", bus.db_estado, 0);
      check("drop_ocup_fim", bus.ocupado, 0);
      repeat (2) @(negedge clock);
      medida(12'h025);
`endif

      check("sb_vazio", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
